// File: rtl/median_window_feeder_pkg.sv
// Shared types and constants for the 3x3 median window feeder.
// Neighbour offset tables are in raster order, top-left first.
package median_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    DONE
  } state_t;

  localparam int DEF_PIX_W = 24;
  localparam int CH_W      = 8;
  localparam int R_LSB     = 16;
  localparam int G_LSB     = 8;
  localparam int B_LSB     = 0;

  localparam int FETCH_LEN = 9;
  localparam int WAIT_LEN  = 2;

  localparam int DX [FETCH_LEN] = '{-1, 0, 1, -1, 0, 1, -1, 0, 1};
  localparam int DY [FETCH_LEN] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};

endpackage

// File: rtl/median_window_feeder_nbr_addr.sv
// Neighbour address generator: centre + offset -> SRAM address and range flag.
// MEDIAN_FEED_EDGE_REPLICATE_EN clamps coordinates to the image instead of flagging them.
module median_nbr_addr
  import median_pkg::*;
#(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int X_W    = $clog2(IMG_W),
  parameter int Y_W    = $clog2(IMG_H),
  parameter int ADDR_W = $clog2(IMG_W * IMG_H)
) (
  input  logic [X_W-1:0]    cx,
  input  logic [Y_W-1:0]    cy,
  input  logic [3:0]        idx,
  output logic [ADDR_W-1:0] addr,
  output logic              in_range
);

  int nx;
  int ny;

  always_comb begin
    nx = int'(cx) + DX[idx];
    ny = int'(cy) + DY[idx];
`ifdef MEDIAN_FEED_EDGE_REPLICATE_EN
    if (nx < 0) nx = 0;
    else if (nx > IMG_W - 1) nx = IMG_W - 1;
    if (ny < 0) ny = 0;
    else if (ny > IMG_H - 1) ny = IMG_H - 1;
    in_range = 1'b1;
`else
    in_range = (nx >= 0) && (nx < IMG_W) && (ny >= 0) && (ny < IMG_H);
`endif
    addr = ADDR_W'(ny * IMG_W + nx);
  end

endmodule

// File: rtl/median_window_feeder.sv
// Fetches the 3x3 neighbourhood of a pixel, streams it into the median sorter and
// registers the result. MEDIAN_FEED_EDGE_REPLICATE_EN selects edge replication over zero padding.
module median_window_feeder
  import median_pkg::*;
#(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int PIX_W  = DEF_PIX_W,
  parameter int ADDR_W = $clog2(IMG_W * IMG_H),
  parameter int X_W    = $clog2(IMG_W),
  parameter int Y_W    = $clog2(IMG_H)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [X_W-1:0]    i_x,
  input  logic [Y_W-1:0]    i_y,
  output logic              o_busy,
  output logic              o_sram_ren,
  output logic [ADDR_W-1:0] o_sram_addr,
  input  logic [PIX_W-1:0]  i_sram_rdata,
  output logic              o_med_clear,
  output logic [PIX_W-1:0]  o_med_data,
  input  logic [PIX_W-1:0]  i_med_result,
  output logic [PIX_W-1:0]  o_pixel,
  output logic              o_valid
);

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [X_W-1:0]    cx;
  logic [Y_W-1:0]    cy;
  logic [ADDR_W-1:0] nbr_addr;
  logic [ADDR_W-1:0] addr_q;
  logic              nbr_in_range;
  logic              fetch_q;
`ifndef MEDIAN_FEED_EDGE_REPLICATE_EN
  logic              ren_q;
`endif

  median_nbr_addr #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .X_W   (X_W),
    .Y_W   (Y_W),
    .ADDR_W(ADDR_W)
  ) u_nbr_addr (
    .cx      (cx),
    .cy      (cy),
    .idx     (cnt),
    .addr    (nbr_addr),
    .in_range(nbr_in_range)
  );

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    o_sram_ren  = 1'b0;
    o_sram_addr = addr_q;
    o_med_clear = 1'b0;
    o_busy      = 1'b0;
    o_valid     = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          state_nxt = FETCH;
          cnt_nxt   = '0;
        end
      end
      FETCH: begin
        o_busy      = 1'b1;
        o_sram_ren  = nbr_in_range;
        o_med_clear = (cnt == '0);
        // Out-of-range neighbours keep the previous address on the bus.
        if (nbr_in_range) o_sram_addr = nbr_addr;
        if (cnt == 4'(FETCH_LEN - 1)) begin
          state_nxt = WAIT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      WAIT: begin
        o_busy = 1'b1;
        if (cnt == 4'(WAIT_LEN - 1)) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      DONE: begin
        o_valid   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef MEDIAN_FEED_EDGE_REPLICATE_EN
  assign o_med_data = fetch_q ? i_sram_rdata : '0;
`else
  assign o_med_data = (fetch_q && ren_q) ? i_sram_rdata : '0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      cx      <= '0;
      cy      <= '0;
      addr_q  <= '0;
      fetch_q <= 1'b0;
`ifndef MEDIAN_FEED_EDGE_REPLICATE_EN
      ren_q   <= 1'b0;
`endif
      o_pixel <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      addr_q  <= o_sram_addr;
      fetch_q <= (state == FETCH);
`ifndef MEDIAN_FEED_EDGE_REPLICATE_EN
      ren_q   <= o_sram_ren;
`endif
      if (state == IDLE && i_start) begin
        cx <= i_x;
        cy <= i_y;
      end
      // Sorter has absorbed all nine samples by the last WAIT cycle.
      if (state == WAIT && cnt == 4'(WAIT_LEN - 1)) o_pixel <= i_med_result;
    end
  end

endmodule

// File: tb/tb_median_window_feeder.sv
// Self-checking bench for median_window_feeder with SRAM and median-sorter models.
module tb_median_window_feeder;

  localparam int W = 8;
  localparam int H = 8;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_start;
  logic [2:0]  i_x;
  logic [2:0]  i_y;
  logic        o_busy;
  logic        o_sram_ren;
  logic [5:0]  o_sram_addr;
  logic [23:0] i_sram_rdata = '0;
  logic        o_med_clear;
  logic [23:0] o_med_data;
  logic [23:0] i_med_result = '0;
  logic [23:0] o_pixel;
  logic        o_valid;

  int n_checks = 0;
  int n_pass   = 0;

  logic [23:0] mem [W*H];
  logic [23:0] sq [$];

  median_window_feeder #(
    .IMG_W (W),
    .IMG_H (H),
    .PIX_W (24)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_x         (i_x),
    .i_y         (i_y),
    .o_busy      (o_busy),
    .o_sram_ren  (o_sram_ren),
    .o_sram_addr (o_sram_addr),
    .i_sram_rdata(i_sram_rdata),
    .o_med_clear (o_med_clear),
    .o_med_data  (o_med_data),
    .i_med_result(i_med_result),
    .o_pixel     (o_pixel),
    .o_valid     (o_valid)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [7:0] med9(input logic [7:0] a [9]);
    logic [7:0] b [9];
    logic [7:0] t;
    b = a;
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (b[j] > b[j+1]) begin
          t = b[j]; b[j] = b[j+1]; b[j+1] = t;
        end
    return b[4];
  endfunction

  function automatic logic [23:0] med_rgb(input logic [23:0] s [9]);
    logic [7:0]  ch [9];
    logic [23:0] m;
    m = '0;
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < 9; k++) ch[k] = s[k][c*8 +: 8];
      m[c*8 +: 8] = med9(ch);
    end
    return m;
  endfunction

  // SRAM with one-cycle read latency.
  always @(posedge i_clk)
    if (o_sram_ren) i_sram_rdata <= mem[o_sram_addr];

  // Sorter: clear empties it, every other edge inserts; result is the per-channel median.
  always @(posedge i_clk) begin : sorter
    logic [23:0] s [9];
    logic [23:0] m;
    if (o_med_clear) sq.delete();
    else if (sq.size() < 9) sq.push_back(o_med_data);
    m = '0;
    if (sq.size() == 9) begin
      for (int k = 0; k < 9; k++) s[k] = sq[k];
      m = med_rgb(s);
    end
    i_med_result <= m;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic load_img(input int mode);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        logic [7:0] v;
        v = 8'(y * W + x);
        case (mode)
          0:       mem[y*W + x] = {v, v, v};
          1:       mem[y*W + x] = {8'(x), 8'(y), 8'(7 - x)};
          default: mem[y*W + x] = 24'($urandom);
        endcase
      end
  endtask

  // Reference: walk the 3x3 window in raster order.
  task automatic model(input int cx, input int cy, output logic [8:0] inr,
                       output int adr [9], output logic [23:0] smp [9],
                       output logic [23:0] med);
    int k;
    k = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++) begin
        int  nx, ny;
        logic ok;
        nx = cx + dx;
        ny = cy + dy;
        ok = (nx >= 0 && nx < W && ny >= 0 && ny < H);
`ifdef MEDIAN_FEED_EDGE_REPLICATE_EN
        nx = (nx < 0) ? 0 : (nx > W - 1) ? W - 1 : nx;
        ny = (ny < 0) ? 0 : (ny > H - 1) ? H - 1 : ny;
        ok = 1'b1;
`endif
        inr[k] = ok;
        adr[k] = ny * W + nx;
        smp[k] = ok ? mem[ny*W + nx] : 24'h0;
        k++;
      end
    med = med_rgb(smp);
  endtask

  task automatic do_req(input int cx, input int cy, input logic [23:0] exp_pix, input string tag);
    logic [8:0]  inr;
    int          adr [9];
    logic [23:0] smp [9];
    logic [23:0] med;
    logic [23:0] dat [9];
    int          got_a [$];
    int          exp_a [$];
    logic [15:0] ren_m  = '0;
    logic [15:0] clr_m  = '0;
    logic [15:0] val_m  = '0;
    logic [15:0] busy_m = '0;
    logic [23:0] pix    = '0;
    model(cx, cy, inr, adr, smp, med);
    for (int k = 0; k < 9; k++) if (inr[k]) exp_a.push_back(adr[k]);
    @(negedge i_clk);
    i_start = 1'b1; i_x = 3'(cx); i_y = 3'(cy);
    @(negedge i_clk);
    i_start = 1'b0;
    for (int t = 1; t <= 14; t++) begin
      ren_m[t]  = o_sram_ren;
      clr_m[t]  = o_med_clear;
      val_m[t]  = o_valid;
      busy_m[t] = o_busy;
      if (o_sram_ren) got_a.push_back(int'(o_sram_addr));
      if (t >= 2 && t <= 10) dat[t-2] = o_med_data;
      if (t == 12) pix = o_pixel;
      @(negedge i_clk);
    end
    check({tag, " ren_mask"},   32'(ren_m),  32'({6'b0, inr, 1'b0}));
    check({tag, " addr_count"}, got_a.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++)
      check($sformatf("%s addr[%0d]", tag, i), got_a[i], exp_a[i]);
    for (int k = 0; k < 9; k++)
      check($sformatf("%s sample[%0d]", tag, k), 32'(dat[k]), 32'(smp[k]));
    check({tag, " clear_mask"}, 32'(clr_m),  32'h0002);
    check({tag, " valid_mask"}, 32'(val_m),  32'h1000);
    check({tag, " busy_mask"},  32'(busy_m), 32'h0FFE);
    check({tag, " pixel"},      32'(pix),    32'(exp_pix));
  endtask

  typedef struct {
    int          cx;
    int          cy;
    int          img;
    logic [23:0] exp_pix;
  } vec_t;

  initial begin
    vec_t        vecs [4];
    logic [31:0] vmask;
    logic [23:0] p12, p25;

    vecs[0] = '{3, 3, 0, 24'h1B1B1B};
`ifdef MEDIAN_FEED_EDGE_REPLICATE_EN
    vecs[1] = '{0, 0, 0, 24'h010101};
    vecs[2] = '{7, 7, 0, 24'h3E3E3E};
`else
    vecs[1] = '{0, 0, 0, 24'h000000};
    vecs[2] = '{7, 7, 0, 24'h000000};
`endif
    vecs[3] = '{4, 2, 1, 24'h040203};

    i_rst_n = 1'b0; i_start = 1'b0; i_x = '0; i_y = '0;
    load_img(0);
    repeat (2) @(negedge i_clk);
    check("reset ctrl", 32'({o_busy, o_sram_ren, o_med_clear, o_valid, o_sram_addr}), 32'h0);
    check("reset med_data", 32'(o_med_data), 32'h0);
    check("reset pixel", 32'(o_pixel), 32'h0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    for (int i = 0; i < 4; i++) begin
      load_img(vecs[i].img);
      do_req(vecs[i].cx, vecs[i].cy, vecs[i].exp_pix, $sformatf("vec%0d", i));
    end

    // Starts at T5 and T12 are ignored; the T13 start is the next accepted request.
    load_img(0);
    vmask = '0; p12 = '0; p25 = '0;
    @(negedge i_clk);
    for (int t = 0; t <= 27; t++) begin
      i_start = (t == 0 || t == 5 || t == 12 || t == 13);
      i_x = (t >= 12) ? 3'd4 : 3'd3;
      i_y = (t >= 12) ? 3'd4 : 3'd3;
      vmask[t] = o_valid;
      if (t == 12) p12 = o_pixel;
      if (t == 25) p25 = o_pixel;
      @(negedge i_clk);
    end
    i_start = 1'b0;
    check("restart valid_mask", vmask, 32'h0200_1000);
    check("restart pixel T12", 32'(p12), 32'h1B1B1B);
    check("restart pixel T25", 32'(p25), 32'h242424);

    // Reset mid-fetch, then a clean request.
    vmask = '0;
    for (int t = 0; t <= 6; t++) begin
      i_start = (t == 0); i_x = 3'd3; i_y = 3'd3;
      if (t == 6) i_rst_n = 1'b0;
      @(negedge i_clk);
    end
    i_start = 1'b0;
    check("midreset ctrl", 32'({o_busy, o_sram_ren, o_med_clear, o_valid, o_sram_addr}), 32'h0);
    check("midreset med_data", 32'(o_med_data), 32'h0);
    check("midreset pixel", 32'(o_pixel), 32'h0);
    i_rst_n = 1'b1;
    for (int t = 0; t < 14; t++) begin
      vmask[t] = o_valid;
      @(negedge i_clk);
    end
    check("midreset no_valid", vmask, 32'h0);
    do_req(5, 5, 24'h2D2D2D, "post_reset");

    load_img(2);
    for (int i = 0; i < 16; i++) begin
      logic [8:0]  inr;
      int          adr [9];
      logic [23:0] smp [9];
      logic [23:0] med;
      int          cx, cy;
      cx = int'($urandom_range(0, W - 1));
      cy = int'($urandom_range(0, H - 1));
      model(cx, cy, inr, adr, smp, med);
      do_req(cx, cy, med, $sformatf("rand%0d(%0d,%0d)", i, cx, cy));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
